// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the arbitrated ALU: opcode values and FSM state encoding.
package alu_share_arbiter_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational WIDTH-bit ALU producing a WIDTH+1 bit result.
// The top bit carries the ADD carry-out or the SUB borrow; it is zero for logic ops.
module alu_core
    import alu_share_arbiter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH:0]   result
);

    // Opcode decode; subtracting zero-extended operands leaves the borrow in the top bit.
    always_comb begin
        result = {(WIDTH+1){1'b0}};
        case (op)
            OP_ADD:  result = {1'b0, a} + {1'b0, b};
            OP_SUB:  result = {1'b0, a} - {1'b0, b};
            OP_AND:  result = {1'b0, a & b};
            OP_OR:   result = {1'b0, a | b};
            default: result = {(WIDTH+1){1'b0}};
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// One transaction in flight: IDLE accepts, EXEC computes, RESP holds the result
// until the owner consumes it. The pointer moves only on response completion.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH:0]   rsp0_data,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH:0]   rsp1_data,
    output logic             busy,
    output logic [CNT_W-1:0] done_count
);

    state_t           state_r;
    logic             ptr_r;
    logic             owner_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [1:0]       op_r;
    logic [WIDTH:0]   rsp0_data_r;
    logic [WIDTH:0]   rsp1_data_r;
    logic             rsp0_valid_r;
    logic             rsp1_valid_r;
    logic             busy_r;
    logic [CNT_W-1:0] done_count_r;

    logic             grant0_s;
    logic             grant1_s;
    logic             owner_ready_s;
    logic [WIDTH:0]   alu_result_s;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .a      (a_r),
        .b      (b_r),
        .op     (op_r),
        .result (alu_result_s)
    );

    // Winner selection in IDLE: a lone valid port wins, ties go to the pointer port.
    // Ready is held low while reset is asserted even though the state decodes as IDLE.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (resetb && (state_r == ST_IDLE)) begin
            if (req0_valid && req1_valid) begin
                if (ptr_r) begin
                    grant1_s = 1'b1;
                end else begin
                    grant0_s = 1'b1;
                end
            end else if (req0_valid) begin
                grant0_s = 1'b1;
            end else if (req1_valid) begin
                grant1_s = 1'b1;
            end else begin
                grant0_s = 1'b0;
                grant1_s = 1'b0;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Response-ready of whichever port owns the in-flight transaction.
    always_comb begin
        owner_ready_s = 1'b0;
        if (owner_r) begin
            owner_ready_s = rsp1_ready;
        end else begin
            owner_ready_s = rsp0_ready;
        end
    end

    // Transaction FSM with operand capture, result registers, pointer and completion counter.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_r      <= ST_IDLE;
            ptr_r        <= 1'b0;
            owner_r      <= 1'b0;
            a_r          <= {WIDTH{1'b0}};
            b_r          <= {WIDTH{1'b0}};
            op_r         <= 2'b00;
            rsp0_data_r  <= {(WIDTH+1){1'b0}};
            rsp1_data_r  <= {(WIDTH+1){1'b0}};
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            done_count_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant0_s) begin
                        a_r     <= req0_a;
                        b_r     <= req0_b;
                        op_r    <= req0_op;
                        owner_r <= 1'b0;
                        busy_r  <= 1'b1;
                        state_r <= ST_EXEC;
                    end else if (grant1_s) begin
                        a_r     <= req1_a;
                        b_r     <= req1_b;
                        op_r    <= req1_op;
                        owner_r <= 1'b1;
                        busy_r  <= 1'b1;
                        state_r <= ST_EXEC;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    if (owner_r) begin
                        rsp1_data_r  <= alu_result_s;
                        rsp1_valid_r <= 1'b1;
                    end else begin
                        rsp0_data_r  <= alu_result_s;
                        rsp0_valid_r <= 1'b1;
                    end
                    state_r <= ST_RESP;
                end
                ST_RESP: begin
                    if (owner_ready_s) begin
                        rsp0_valid_r <= 1'b0;
                        rsp1_valid_r <= 1'b0;
                        done_count_r <= done_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        ptr_r        <= ~owner_r;
                        busy_r       <= 1'b0;
                        state_r      <= ST_IDLE;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    rsp0_valid_r <= 1'b0;
                    rsp1_valid_r <= 1'b0;
                    busy_r       <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;
    assign rsp0_valid = rsp0_valid_r;
    assign rsp1_valid = rsp1_valid_r;
    assign rsp0_data  = rsp0_data_r;
    assign rsp1_data  = rsp1_data_r;
    assign busy       = busy_r;
    assign done_count = done_count_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter (WIDTH=4, CNT_W=8).
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic             clock = 1'b0;
    logic             resetb;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]       req0_op, req1_op;
    logic             rsp0_valid, rsp1_valid;
    logic             rsp0_ready, rsp1_ready;
    logic [WIDTH:0]   rsp0_data, rsp1_data;
    logic             busy;
    logic [CNT_W-1:0] done_count;

    int n_checks = 0;
    int n_fail   = 0;

    alu_share_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .resetb     (resetb),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_data  (rsp0_data),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_data  (rsp1_data),
        .busy       (busy),
        .done_count (done_count)
    );

    // Free-running clock, 10 ns period.
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    // One complete transaction on a single port, starting and ending at a falling edge in IDLE.
    task automatic run_op(input int port, input logic [3:0] a, input logic [3:0] b,
                          input logic [1:0] op, input logic [4:0] exp, input logic [7:0] done_exp);
        if (port == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end
        #1;
        check("op_req_ready", (port == 0) ? req0_ready : req1_ready, 1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        check("op_busy_exec", busy, 1);
        check("op_rsp_valid_exec", (port == 0) ? rsp0_valid : rsp1_valid, 0);
        tick();
        #1;
        check("op_rsp_valid", (port == 0) ? rsp0_valid : rsp1_valid, 1);
        check("op_rsp_data", (port == 0) ? rsp0_data : rsp1_data, exp);
        check("op_no_ready_resp", {req0_ready, req1_ready}, 0);
        if (port == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        #1;
        check("op_rsp_valid_clr", {rsp0_valid, rsp1_valid}, 0);
        check("op_busy_clr", busy, 0);
        check("op_done_count", done_count, done_exp);
    endtask

    initial begin
        int gport[4];
        int ngrant;

        resetb = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 4'b1001; req0_b = 4'b1001; req0_op = OP_ADD;
        req1_valid = 1'b1; req1_a = 4'd3;    req1_b = 4'd5;    req1_op = OP_SUB;

        // Reset with both requests pending
        repeat (3) @(negedge clock);
        #1;
        check("rst_req_ready", {req0_ready, req1_ready}, 0);
        check("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done_count, 0);
        check("rst_rsp0_data", rsp0_data, 0);
        check("rst_rsp1_data", rsp1_data, 0);
        resetb = 1'b1;
        #1;
        check("rel_req0_ready", req0_ready, 1);
        check("rel_req1_ready", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        check("first_busy", busy, 1);
        tick();
        #1;
        check("first_rsp0_valid", rsp0_valid, 1);
        check("first_rsp0_data", rsp0_data, 5'b10010);
        check("first_rsp1_valid", rsp1_valid, 0);
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        #1;
        check("first_done", done_count, 1);
        check("first_busy_clr", busy, 0);

        // Opcodes on port 1
        run_op(1, 4'd3, 4'd5, OP_SUB, 5'b11110, 8'd2);
        run_op(1, 4'hC, 4'hA, OP_AND, 5'b01000, 8'd3);
        run_op(1, 4'hC, 4'hA, OP_OR,  5'b01110, 8'd4);
        run_op(1, 4'hF, 4'h1, OP_ADD, 5'b10000, 8'd5);
        check("nonowner_data_kept", rsp0_data, 5'b10010);

        // Contention: both valid, both rsp_ready high for 12 cycles
        req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd2; req0_op = OP_ADD;
        req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'd2; req1_op = OP_OR;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        ngrant = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (req0_ready) begin
                if (ngrant < 4) gport[ngrant] = 0;
                ngrant++;
            end
            if (req1_ready) begin
                if (ngrant < 4) gport[ngrant] = 1;
                ngrant++;
            end
            if (rsp0_valid) check("cont_rsp0_data", rsp0_data, 5'd3);
            if (rsp1_valid) check("cont_rsp1_data", rsp1_data, 5'd7);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        #1;
        check("cont_done", done_count, 9);
        check("cont_ngrant", ngrant, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < ngrant) check("cont_grant_order", gport[i], i % 2);
        end

        // Backpressure on port 0 with port 1 waiting
        req0_valid = 1'b1; req0_a = 4'hF; req0_b = 4'h3; req0_op = OP_AND;
        req1_valid = 1'b1; req1_a = 4'h4; req1_b = 4'h1; req1_op = OP_SUB;
        #1;
        check("bp_prio0", req0_ready, 1);
        check("bp_prio1", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_rsp0_valid", rsp0_valid, 1);
            check("bp_rsp0_data", rsp0_data, 5'b00011);
            check("bp_req_ready", {req0_ready, req1_ready}, 0);
            check("bp_busy", busy, 1);
            tick();
        end
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        #1;
        check("bp_done", done_count, 10);
        check("bp_next_req1", req1_ready, 1);
        check("bp_next_req0", req0_ready, 0);
        tick();
        req1_valid = 1'b0;
        tick();
        #1;
        check("bp_rsp1_valid", rsp1_valid, 1);
        check("bp_rsp1_data", rsp1_data, 5'b00011);
        rsp1_ready = 1'b1;
        tick();
        rsp1_ready = 1'b0;
        #1;
        check("bp_done2", done_count, 11);

        // Reset in EXEC after moving the pointer to port 1
        run_op(0, 4'd2, 4'd2, OP_ADD, 5'd4, 8'd12);
        req1_valid = 1'b1; req1_a = 4'd6; req1_b = 4'd1; req1_op = OP_SUB;
        #1;
        check("mid_req1_ready", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        resetb = 1'b0;
        #1;
        check("mid_busy", busy, 0);
        check("mid_done", done_count, 0);
        tick();
        resetb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("mid_no_rsp", {rsp0_valid, rsp1_valid}, 0);
            tick();
        end
        check("mid_rsp1_data", rsp1_data, 0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("mid_ptr0_req0", req0_ready, 1);
        check("mid_ptr0_req1", req1_ready, 0);
        req1_valid = 1'b0;
        run_op(0, 4'd7, 4'd8, OP_ADD, 5'd15, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
